// File: rtl/axi4_ram_slave_if.sv
// AXI4 bundle shared by bus masters and the RAM slave endpoint.
interface axi4_ifc #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 1
);
    logic [IWIDTH-1:0]   awid;
    logic [AWIDTH-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DWIDTH-1:0]   wdata;
    logic [DWIDTH/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [IWIDTH-1:0]   bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [IWIDTH-1:0]   arid;
    logic [AWIDTH-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [IWIDTH-1:0]   rid;
    logic [DWIDTH-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_ram_slave.sv
// AXI4 slave backed by a word RAM: one burst at a time, INCR/FIXED, byte strobes,
// 2-entry read prefetch so a held rready sustains one beat per clock.
module axi4_ram_slave #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 1,
    parameter int ABITS  = 10
) (
    input logic    clk,
    input logic    reset,
    axi4_ifc.slave s
);
    localparam int NBYTES = DWIDTH / 8;
    localparam int DEPTH  = 1 << ABITS;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
    state_t r_state, w_next;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic              r_last_was_read;
    logic [IWIDTH-1:0] r_id;
    logic [ABITS-1:0]  r_idx;
    logic [7:0]        r_len;
    logic [7:0]        r_beat;
    logic              r_fixed;
    logic              r_err;
    // Read prefetch ring: RAM output lands directly in an entry
    logic [DWIDTH-1:0] r_fd [2];
    logic              r_fl [2];
    logic              r_wp, r_rp;
    logic [1:0]        r_cnt;
    logic [7:0]        r_rbeat;
    logic              r_rdone;

    logic w_grant_w, w_grant_r, w_aw_hs, w_ar_hs, w_w_hs, w_w_final;
    logic w_rvalid, w_r_hs, w_r_final, w_issue;

    assign w_grant_w = s.awvalid & (~s.arvalid | r_last_was_read);
    assign w_grant_r = s.arvalid & (~s.awvalid | ~r_last_was_read);
    assign w_aw_hs   = ~reset & (r_state == IDLE) & w_grant_w;
    assign w_ar_hs   = ~reset & (r_state == IDLE) & w_grant_r;
    assign w_w_hs    = (r_state == WDATA) & s.wvalid;
    assign w_w_final = (r_beat == r_len);
    assign w_rvalid  = (r_cnt != 2'd0);
    assign w_r_hs    = w_rvalid & s.rready;
    assign w_r_final = w_r_hs & r_fl[r_rp];
    assign w_issue   = (r_state == RDATA) & ~r_rdone & ((r_cnt != 2'd2) | w_r_hs);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_aw_hs) w_next = WDATA;
                     else if (w_ar_hs) w_next = RDATA;
            WDATA:   if (w_w_hs && w_w_final) w_next = WRESP;
            WRESP:   if (s.bready) w_next = IDLE;
            RDATA:   if (w_r_final) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_was_read <= 1'b1;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_cnt   <= '0;
            r_rbeat <= '0;
            r_rdone <= 1'b0;
        end else begin
            // Only a contended grant moves the fairness flag
            if (r_state == IDLE && s.awvalid && s.arvalid) r_last_was_read <= w_grant_r;
            if (w_aw_hs) begin
                r_id    <= s.awid;
                r_idx   <= s.awaddr[ABITS+1:2];
                r_len   <= s.awlen;
                r_fixed <= (s.awburst == 2'b00);
                r_beat  <= '0;
                r_err   <= 1'b0;
            end else if (w_ar_hs) begin
                r_id    <= s.arid;
                r_idx   <= s.araddr[ABITS+1:2];
                r_len   <= s.arlen;
                r_fixed <= (s.arburst == 2'b00);
                r_rbeat <= '0;
                r_rdone <= 1'b0;
            end
            if (w_w_hs) begin
                if (s.wlast != w_w_final) r_err <= 1'b1;
                r_beat <= r_beat + 8'd1;
                if (!r_fixed) r_idx <= r_idx + ABITS'(1);
            end
            if (r_state == WRESP && s.bready) r_err <= 1'b0;
            if (w_issue) begin
                r_wp    <= ~r_wp;
                r_rbeat <= r_rbeat + 8'd1;
                if (r_rbeat == r_len) r_rdone <= 1'b1;
                if (!r_fixed) r_idx <= r_idx + ABITS'(1);
            end
            if (w_r_hs) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_issue} - {1'b0, w_r_hs};
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs && !reset) begin
            for (int b = 0; b < NBYTES; b++)
                if (s.wstrb[b]) r_mem[r_idx][8*b +: 8] <= s.wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_fd[r_wp] <= r_mem[r_idx];
            r_fl[r_wp] <= (r_rbeat == r_len);
        end
    end

    always_comb begin
        s.awready = w_aw_hs;
        s.arready = w_ar_hs;
        s.wready  = (r_state == WDATA);
        s.bvalid  = (r_state == WRESP);
        s.bid     = '0;
        s.bresp   = 2'b00;
        if (r_state == WRESP) begin
            s.bid   = r_id;
            s.bresp = r_err ? 2'b10 : 2'b00;
        end
        s.rvalid = w_rvalid;
        s.rid    = '0;
        s.rdata  = '0;
        s.rlast  = 1'b0;
        s.rresp  = 2'b00;
        if (w_rvalid) begin
            s.rid   = r_id;
            s.rdata = r_fd[r_rp];
            s.rlast = r_fl[r_rp];
        end
    end

    logic w_unused;
    assign w_unused = ^{s.awsize, s.awlock, s.awcache, s.awprot, s.awaddr[AWIDTH-1:ABITS+2],
                        s.awaddr[1:0], s.arsize, s.arlock, s.arcache, s.arprot,
                        s.araddr[AWIDTH-1:ABITS+2], s.araddr[1:0]};
endmodule

// File: tb/tb_axi4_ram_slave.sv
// Bench for axi4_ram_slave: directed scenarios plus random bursts against a word-array model.
module tb_axi4_ram_slave;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] ref_mem [DEPTH];
    bit   lwr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi4_ifc #(.AWIDTH(32), .DWIDTH(32), .IWIDTH(1)) bus ();

    axi4_ram_slave #(.AWIDTH(32), .DWIDTH(32), .IWIDTH(1), .ABITS(10)) dut (
        .clk(clk), .reset(reset), .s(bus)
    );

    // ---------------- reference model ----------------
    task automatic m_write(input logic [31:0] addr, input logic [1:0] burst,
                           input logic [31:0] d[$], input logic [3:0] st[$]);
        int idx = int'((addr >> 2) % DEPTH);
        for (int i = 0; i < d.size(); i++) begin
            for (int b = 0; b < 4; b++)
                if (st[i][b]) ref_mem[idx][8*b +: 8] = d[i][8*b +: 8];
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        end
    endtask

    task automatic m_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          output logic [31:0] q[$]);
        int idx = int'((addr >> 2) % DEPTH);
        q = {};
        for (int i = 0; i <= len; i++) begin
            q.push_back(ref_mem[idx]);
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        end
    endtask

    // ---------------- bus drivers ----------------
    task automatic set_aw(input logic [31:0] a, input logic id, input logic [7:0] len,
                          input logic [1:0] burst);
        bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awburst = burst;
        bus.awsize = 3'd2; bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awvalid = 1;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic id, input logic [7:0] len,
                          input logic [1:0] burst);
        bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arburst = burst;
        bus.arsize = 3'd2; bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arvalid = 1;
    endtask

    task automatic wait_aw(output bit to);
        bit got = 0;
        int n = 0;
        while (!got && n < 2000) begin
            #1 got = bus.awready;
            @(negedge clk); n++;
        end
        bus.awvalid = 0;
        to = !got;
    endtask

    task automatic wait_ar(output int hs_cyc, output bit to);
        bit got = 0;
        int n = 0;
        hs_cyc = -1;
        while (!got && n < 2000) begin
            #1 got = bus.arready;
            if (got) hs_cyc = cyc;
            @(negedge clk); n++;
        end
        bus.arvalid = 0;
        to = !got;
    endtask

    task automatic send_w(input logic [31:0] d[$], input logic [3:0] st[$], input int bad_last,
                          output bit to);
        to = 0;
        for (int i = 0; i < d.size(); i++) begin
            bit got = 0;
            int n = 0;
            bus.wdata = d[i]; bus.wstrb = st[i]; bus.wvalid = 1;
            bus.wlast = (bad_last >= 0) ? (i == bad_last) : (i == d.size() - 1);
            while (!got && n < 200) begin
                #1 got = bus.wready;
                @(negedge clk); n++;
            end
            if (!got) to = 1;
        end
        bus.wvalid = 0; bus.wlast = 0;
    endtask

    task automatic recv_b(output logic [1:0] resp, output logic id, output bit to);
        bit got = 0;
        int n = 0;
        resp = 2'bxx; id = 1'bx;
        bus.bready = 1;
        while (!got && n < 200) begin
            #1 if (bus.bvalid) begin got = 1; resp = bus.bresp; id = bus.bid; end
            @(negedge clk); n++;
        end
        bus.bready = 0;
        to = !got;
    endtask

    task automatic recv_r(input int nb, input bit toggle, output logic [31:0] d[$], output bit l[$],
                          output logic ids[$], output int first_cyc, output int last_cyc,
                          output int stall_bad, output bit to);
        logic [31:0] pd = 0;
        bit pl = 0;
        logic pid = 0;
        bit stalled = 0;
        int n = 0;
        d = {}; l = {}; ids = {}; first_cyc = -1; last_cyc = -1; stall_bad = 0;
        while (d.size() < nb && n < 4000) begin
            bus.rready = !toggle || (n % 4 == 0) || (n % 4 == 3);
            #1;
            if (bus.rvalid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stalled && (bus.rdata !== pd || bus.rlast !== pl || bus.rid !== pid)) stall_bad++;
                if (bus.rready) begin
                    d.push_back(bus.rdata); l.push_back(bus.rlast); ids.push_back(bus.rid);
                    last_cyc = cyc; stalled = 0;
                end else begin
                    stalled = 1; pd = bus.rdata; pl = bus.rlast; pid = bus.rid;
                end
            end
            @(negedge clk); n++;
        end
        bus.rready = 0;
        to = (d.size() < nb);
    endtask

    task automatic do_write(input logic [31:0] a, input logic id, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] d[$], input logic [3:0] st[$],
                            input int bad_last, output logic [1:0] resp, output logic bid, output bit to);
        bit t1, t2, t3;
        @(negedge clk);
        set_aw(a, id, len, burst);
        wait_aw(t1);
        send_w(d, st, bad_last, t2);
        recv_b(resp, bid, t3);
        to = t1 | t2 | t3;
        if (!t1) m_write(a, burst, d, st);
    endtask

    task automatic do_read(input logic [31:0] a, input logic id, input logic [7:0] len,
                           input logic [1:0] burst, input bit toggle, output logic [31:0] d[$],
                           output bit l[$], output logic ids[$], output int lat, output int span,
                           output int stall_bad, output bit to);
        int hs, fc, lc;
        bit t1, t2;
        @(negedge clk);
        set_ar(a, id, len, burst);
        wait_ar(hs, t1);
        recv_r(int'(len) + 1, toggle, d, l, ids, fc, lc, stall_bad, t2);
        lat = fc - hs; span = lc - fc; to = t1 | t2;
    endtask

    // Compares a received burst against the model, beat by beat.
    task automatic test_read_vs_model(input string nm, input logic [31:0] a, input logic id,
                                      input logic [7:0] len, input logic [1:0] burst, input bit toggle);
        logic [31:0] d[$], e[$];
        bit l[$];
        logic ids[$];
        int lat, span, sb;
        bit to;
        m_read(a, int'(len), burst, e);
        do_read(a, id, len, burst, toggle, d, l, ids, lat, span, sb, to);
        checks++;
        if (to || sb != 0) begin
            errors++; $display("FAIL %s handshake: timeout %0d stalls_changed %0d required 0 0", nm, to, sb);
        end
        for (int i = 0; i < d.size(); i++) begin
            checks++;
            if (d[i] !== e[i] || l[i] !== (i == int'(len)) || ids[i] !== id) begin
                errors++;
                $display("FAIL %s beat %0d: data %h last %0d id %0d required %h %0d %0d",
                         nm, i, d[i], l[i], ids[i], e[i], (i == int'(len)), id);
            end
        end
        #1 checks++;
        if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL %s rvalid_drop: got %b required 0", nm, bus.rvalid); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [15:0] obs;
        bus.awvalid = 1; bus.arvalid = 1; bus.wvalid = 1; bus.bready = 0; bus.rready = 0;
        bus.awaddr = 0; bus.araddr = 0; bus.awid = 0; bus.arid = 0; bus.awlen = 0; bus.arlen = 0;
        bus.awburst = 1; bus.arburst = 1; bus.awsize = 2; bus.arsize = 2; bus.awlock = 0; bus.arlock = 0;
        bus.awcache = 0; bus.arcache = 0; bus.awprot = 0; bus.arprot = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        reset = 1;
        repeat (3) @(negedge clk);
        #1 obs = {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast,
                  bus.bresp, bus.rresp, bus.bid, bus.rid, 4'h0};
        checks++;
        if (obs !== 16'h0) begin errors++; $display("FAIL reset_ctrl: got %h required 0000", obs); end
        checks++;
        if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", bus.rdata); end
        @(negedge clk);
        bus.awvalid = 0; bus.arvalid = 0; bus.wvalid = 0;
        reset = 0; lwr = 1;
    endtask

    task automatic test_prefill();
        logic [31:0] dq[$];
        logic [3:0] sq[$];
        logic [1:0] resp;
        logic bid;
        bit to;
        for (int k = 0; k < 4; k++) begin
            dq = {}; sq = {};
            for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
            do_write(32'(k * 1024), 0, 8'd255, 2'b01, dq, sq, -1, resp, bid, to);
            checks++;
            if (to || resp !== 2'b00) begin errors++; $display("FAIL prefill_%0d: resp %b timeout %0d required 00 0", k, resp, to); end
        end
    endtask

    task automatic test_single();
        logic [31:0] dq[$], d[$];
        logic [3:0] sq[$];
        bit l[$];
        logic ids[$];
        logic [1:0] resp;
        logic bid;
        int lat, span, sb;
        bit to;
        dq = {32'hDEADBEEF}; sq = {4'hF};
        do_write(32'h10, 1, 0, 2'b01, dq, sq, -1, resp, bid, to);
        checks++;
        if (to || resp !== 2'b00 || bid !== 1'b1) begin
            errors++; $display("FAIL single_b: resp %b id %b timeout %0d required 00 1 0", resp, bid, to);
        end
        do_read(32'h10, 1, 0, 2'b01, 0, d, l, ids, lat, span, sb, to);
        checks++;
        if (to || d[0] !== 32'hDEADBEEF || l[0] !== 1'b1 || ids[0] !== 1'b1) begin
            errors++; $display("FAIL single_r: data %h last %0d id %0d required deadbeef 1 1", d[0], l[0], ids[0]);
        end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d required 2", lat); end
    endtask

    task automatic test_strobe_burst();
        logic [31:0] dq[$], d[$], e[$];
        logic [3:0] sq[$];
        bit l[$];
        logic ids[$];
        logic [1:0] resp;
        logic bid;
        int lat, span, sb;
        bit to;
        dq = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
        do_write(32'h100, 0, 3, 2'b01, dq, sq, -1, resp, bid, to);
        dq = {32'd0, 32'd1, 32'd2, 32'd3}; sq = {4'hF, 4'h3, 4'hF, 4'hF};
        do_write(32'h100, 0, 3, 2'b01, dq, sq, -1, resp, bid, to);
        e = {32'h0, 32'hFFFF0001, 32'h2, 32'h3};
        do_read(32'h100, 0, 3, 2'b01, 0, d, l, ids, lat, span, sb, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (to || d[i] !== e[i] || l[i] !== (i == 3)) begin
                errors++; $display("FAIL strobe beat %0d: data %h last %0d required %h %0d", i, d[i], l[i], e[i], (i == 3));
            end
        end
        checks++;
        if (span != 3) begin errors++; $display("FAIL strobe_throughput: span %0d required 3", span); end
    endtask

    task automatic test_backpressure();
        logic [31:0] dq[$];
        logic [3:0] sq[$];
        logic [1:0] resp;
        logic bid;
        bit t1, t2, t3;
        test_read_vs_model("bp_read", 32'h400 + 32'($urandom_range(0, 63) * 4), 1, 7, 2'b01, 1);
        dq = {$urandom}; sq = {4'hF};
        @(negedge clk);
        set_aw(32'h40, 0, 0, 2'b01);
        wait_aw(t1);
        send_w(dq, sq, -1, t2);
        m_write(32'h40, 2'b01, dq, sq);
        set_aw(32'h80, 1, 0, 2'b01);
        for (int i = 0; i < 5; i++) begin
            #1 checks++;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
                errors++; $display("FAIL bp_bhold cycle %0d: bvalid %b awready %b required 1 0", i, bus.bvalid, bus.awready);
            end
            @(negedge clk);
        end
        bus.awvalid = 0;
        recv_b(resp, bid, t3);
        checks++;
        if (t1 || t2 || t3 || resp !== 2'b00) begin errors++; $display("FAIL bp_bresp: resp %b required 00", resp); end
        test_read_vs_model("bp_after", 32'h40, 0, 0, 2'b01, 0);
    endtask

    task automatic test_fixed_wrap();
        logic [31:0] dq[$];
        logic [3:0] sq[$];
        logic [1:0] resp;
        logic bid;
        bit to;
        dq = {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003}; sq = {4'hF, 4'hF, 4'hF};
        do_write(32'h20, 0, 2, 2'b00, dq, sq, -1, resp, bid, to);
        checks++;
        if (ref_mem[8] !== 32'hCCCC0003) begin errors++; $display("FAIL fixed_model: got %h required cccc0003", ref_mem[8]); end
        test_read_vs_model("fixed", 32'h20, 0, 2, 2'b00, 0);
        dq = {$urandom, $urandom}; sq = {4'hF, 4'hF};
        do_write(32'hFFC, 1, 1, 2'b01, dq, sq, -1, resp, bid, to);
        test_read_vs_model("wrap_top", 32'hFFC, 1, 1, 2'b10, 0);
        test_read_vs_model("wrap_zero", 32'h0, 0, 0, 2'b11, 0);
        test_read_vs_model("alias", 32'h1000, 0, 0, 2'b01, 0);
    endtask

    task automatic test_wlast_err();
        logic [31:0] dq[$];
        logic [3:0] sq[$];
        logic [1:0] resp;
        logic bid;
        bit to;
        dq = {$urandom, $urandom, $urandom}; sq = {4'hF, 4'hF, 4'hF};
        do_write(32'h200, 1, 2, 2'b01, dq, sq, 1, resp, bid, to);
        checks++;
        if (to || resp !== 2'b10) begin errors++; $display("FAIL wlast_err_bresp: got %b required 10", resp); end
        test_read_vs_model("wlast_err_data", 32'h200, 1, 2, 2'b01, 0);
        dq = {$urandom}; sq = {4'hF};
        do_write(32'h210, 0, 0, 2'b01, dq, sq, -1, resp, bid, to);
        checks++;
        if (to || resp !== 2'b00) begin errors++; $display("FAIL wlast_clear_bresp: got %b required 00", resp); end
    endtask

    task automatic test_arbitration();
        logic [31:0] dq[$], d[$], e[$];
        logic [3:0] sq[$];
        logic [1:0] resp;
        logic bid;
        bit l[$];
        logic ids[$];
        int hs, fc, lc, sb;
        bit exp_w, t1, t2, t3, t4;
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; lwr = 1;
        // contention 1
        dq = {$urandom}; sq = {4'hF};
        set_aw(32'h300, 1, 0, 2'b01);
        set_ar(32'h300, 0, 0, 2'b01);
        exp_w = lwr;
        #1 checks++;
        if (bus.awready !== exp_w || bus.arready !== !exp_w) begin
            errors++; $display("FAIL arb_first: awready %b arready %b required %b %b", bus.awready, bus.arready, exp_w, !exp_w);
        end
        lwr = !exp_w;
        wait_aw(t1); send_w(dq, sq, -1, t2); recv_b(resp, bid, t3);
        m_write(32'h300, 2'b01, dq, sq);
        wait_ar(hs, t4);
        recv_r(1, 0, d, l, ids, fc, lc, sb, t1);
        checks++;
        if (d.size() != 1 || d[0] !== dq[0]) begin errors++; $display("FAIL arb_raw: got %h required %h", d[0], dq[0]); end
        // contention 2
        dq = {$urandom}; sq = {4'hF};
        set_aw(32'h304, 0, 0, 2'b01);
        set_ar(32'h300, 1, 0, 2'b01);
        exp_w = lwr;
        #1 checks++;
        if (bus.awready !== exp_w || bus.arready !== !exp_w) begin
            errors++; $display("FAIL arb_second: awready %b arready %b required %b %b", bus.awready, bus.arready, exp_w, !exp_w);
        end
        lwr = !exp_w;
        m_read(32'h300, 0, 2'b01, e);
        wait_ar(hs, t4);
        recv_r(1, 0, d, l, ids, fc, lc, sb, t1);
        checks++;
        if (d.size() != 1 || d[0] !== e[0]) begin errors++; $display("FAIL arb_read2: got %h required %h", d[0], e[0]); end
        wait_aw(t1); send_w(dq, sq, -1, t2); recv_b(resp, bid, t3);
        m_write(32'h304, 2'b01, dq, sq);
        test_read_vs_model("arb_write2", 32'h304, 0, 0, 2'b01, 0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d[$], e[$];
        bit l[$];
        logic ids[$];
        int hs, fc, lc, sb;
        bit t1, t2;
        logic [31:0] a = 32'($urandom_range(0, 1000) * 4);
        m_read(a, 5, 2'b01, e);
        @(negedge clk);
        set_ar(a, 0, 5, 2'b01);
        wait_ar(hs, t1);
        recv_r(2, 0, d, l, ids, fc, lc, sb, t2);
        checks++;
        if (t1 || t2 || d[0] !== e[0] || d[1] !== e[1]) begin errors++; $display("FAIL rmid_partial: got %h %h required %h %h", d[0], d[1], e[0], e[1]); end
        reset = 1;
        @(negedge clk);
        #1 checks++;
        if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++; $display("FAIL rmid_outputs: rvalid %b rlast %b rdata %h required 0 0 0", bus.rvalid, bus.rlast, bus.rdata);
        end
        @(negedge clk);
        reset = 0; lwr = 1;
        set_ar(a, 1, 5, 2'b01);
        #1 checks++;
        if (bus.arready !== 1'b1) begin errors++; $display("FAIL rmid_idle: arready %b required 1", bus.arready); end
        bus.arvalid = 0;
        test_read_vs_model("rmid_reread", a, 1, 5, 2'b01, 0);
    endtask

    task automatic test_random();
        logic [31:0] dq[$];
        logic [3:0] sq[$];
        logic [1:0] resp;
        logic bid, id;
        bit to;
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a = $urandom;
            logic [7:0] len = 8'($urandom_range(0, 15));
            logic [1:0] burst = 2'($urandom_range(0, 3));
            id = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                dq = {}; sq = {};
                for (int i = 0; i <= int'(len); i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
                do_write(a, id, len, burst, dq, sq, -1, resp, bid, to);
                checks++;
                if (to || resp !== 2'b00 || bid !== id) begin
                    errors++; $display("FAIL rand_write %0d: resp %b id %b required 00 %b", it, resp, bid, id);
                end
            end else begin
                test_read_vs_model("rand_read", a, id, len, burst, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_single();
        test_strobe_burst();
        test_backpressure();
        test_fixed_wrap();
        test_wlast_err();
        test_arbitration();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
